delay_unit_arbiter: RTL and testbench

- Shares one ready/valid delay-unit channel between two requester streams (I_0, I_1) using round-robin issue.
- Records the source of every issued beat in an in-order tag FIFO and steers the delay unit's returns back to O_0/O_1.
- Sits in Main between the top-level tuple ports and a single-lane delay unit instance.
- The delay unit returns beats in issue order, with arbitrary latency.

---
 rtl/delay_unit_arbiter_pkg.sv | 10 +
 rtl/delay_unit_arbiter_if.sv | 44 ++++
 rtl/delay_unit_arbiter_tag_fifo.sv | 52 +++++
 rtl/delay_unit_arbiter.sv | 103 ++++++++++
 tb/tb_delay_unit_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_unit_arbiter_pkg.sv
// Shared types and defaults for the two-requester delay-unit arbiter.
package delay_unit_arbiter_pkg;

   localparam int DEFAULT_WIDTH = 5;
   localparam int DEFAULT_DEPTH = 4;

   // Source of an issued beat: 0 = requester 0, 1 = requester 1.
   typedef logic tag_t;

endpackage

// File: rtl/delay_unit_arbiter_if.sv
// Ready/valid bundle for the arbiter: two requesters, the delay-unit channel, two return streams.
interface delay_unit_arbiter_if
   import delay_unit_arbiter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic [WIDTH-1:0] I_0_data;
   logic             I_0_valid;
   logic             I_0_ready;
   logic [WIDTH-1:0] I_1_data;
   logic             I_1_valid;
   logic             I_1_ready;
   logic [WIDTH-1:0] DU_IN_data;
   logic             DU_IN_valid;
   logic             DU_IN_ready;
   logic [WIDTH-1:0] DU_OUT_data;
   logic             DU_OUT_valid;
   logic             DU_OUT_ready;
   logic [WIDTH-1:0] O_0_data;
   logic             O_0_valid;
   logic             O_0_ready;
   logic [WIDTH-1:0] O_1_data;
   logic             O_1_valid;
   logic             O_1_ready;

   modport slave (
      input  I_0_data, I_0_valid, output I_0_ready,
      input  I_1_data, I_1_valid, output I_1_ready,
      output DU_IN_data, DU_IN_valid, input DU_IN_ready,
      input  DU_OUT_data, DU_OUT_valid, output DU_OUT_ready,
      output O_0_data, O_0_valid, input O_0_ready,
      output O_1_data, O_1_valid, input O_1_ready
   );

   modport master (
      output I_0_data, I_0_valid, input I_0_ready,
      output I_1_data, I_1_valid, input I_1_ready,
      input  DU_IN_data, DU_IN_valid, output DU_IN_ready,
      output DU_OUT_data, DU_OUT_valid, input DU_OUT_ready,
      input  O_0_data, O_0_valid, output O_0_ready,
      input  O_1_data, O_1_valid, output O_1_ready
   );

endinterface

// File: rtl/delay_unit_arbiter_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding delay-unit beat.
module delay_unit_arbiter_tag_fifo
   import delay_unit_arbiter_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                   CLK,
   input  logic                   ASYNCRESET,
   input  logic                   push_i,
   input  tag_t                   push_tag_i,
   input  logic                   pop_i,
   output tag_t                   head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   tag_t          mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;

   // NOTE: tag storage is deliberately not reset; an entry is only read once count_q covers it.
   always_ff @(posedge CLK) begin
      if (push_i) mem_q[wr_ptr_q] <= push_tag_i;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/delay_unit_arbiter.sv
// Round-robin share of one delay-unit channel between two requesters, with in-order return steering.
// Optional assertions: define DELAY_UNIT_ARBITER_ASSERT_EN.
module delay_unit_arbiter
   import delay_unit_arbiter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                   CLK,
   input  logic                   ASYNCRESET,
   delay_unit_arbiter_if.slave    bus,
   output logic [$clog2(DEPTH):0] OUTSTANDING,
   output logic                   ERR
);
   tag_t last_grant_q, last_grant_d;
   tag_t grant;
   tag_t head;
   logic err_q, err_d;
   logic full, empty;
   logic can_issue, grant_valid, head_ready;
   logic push, pop;

   // NOTE: grant gets a default before the overrides, so no path leaves it unassigned (no latch).
   always_comb begin
      grant = ~last_grant_q;
      if (bus.I_0_valid && !bus.I_1_valid)      grant = 1'b0;
      else if (bus.I_1_valid && !bus.I_0_valid) grant = 1'b1;
   end

   // Handshake outputs are forced low while reset is held, independent of the inputs.
   assign can_issue       = bus.DU_IN_ready & ~full & ~ASYNCRESET;
   assign grant_valid     = grant ? bus.I_1_valid : bus.I_0_valid;
   assign bus.DU_IN_valid = grant_valid & ~full & ~ASYNCRESET;
   assign bus.DU_IN_data  = grant ? bus.I_1_data : bus.I_0_data;
   assign bus.I_0_ready   = can_issue & ~grant;
   assign bus.I_1_ready   = can_issue & grant;
   assign push            = bus.DU_IN_valid & bus.DU_IN_ready;

   assign head_ready       = head ? bus.O_1_ready : bus.O_0_ready;
   assign bus.O_0_valid    = bus.DU_OUT_valid & ~empty & ~head & ~ASYNCRESET;
   assign bus.O_1_valid    = bus.DU_OUT_valid & ~empty & head & ~ASYNCRESET;
   assign bus.O_0_data     = bus.DU_OUT_data;
   assign bus.O_1_data     = bus.DU_OUT_data;
   assign bus.DU_OUT_ready = ~empty & head_ready & ~ASYNCRESET;
   assign pop              = bus.DU_OUT_valid & bus.DU_OUT_ready;

   assign last_grant_d = push ? grant : last_grant_q;
   assign err_d        = err_q | (bus.DU_OUT_valid & empty);

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         last_grant_q <= 1'b1;
         err_q        <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         err_q        <= err_d;
      end
   end

   delay_unit_arbiter_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
      .CLK        (CLK),
      .ASYNCRESET (ASYNCRESET),
      .push_i     (push),
      .push_tag_i (grant),
      .pop_i      (pop),
      .head_o     (head),
      .full_o     (full),
      .empty_o    (empty),
      .count_o    (OUTSTANDING)
   );

   assign ERR = err_q;

`ifdef DELAY_UNIT_ARBITER_ASSERT_EN
   // Issue opportunities each requester has lost while waiting; round-robin bounds this at 1.
   logic [1:0] lost_0_q, lost_1_q;

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         lost_0_q <= '0;
         lost_1_q <= '0;
      end else begin
         if (!bus.I_0_valid || bus.I_0_ready) lost_0_q <= '0;
         else if (can_issue && lost_0_q != 2'd3) lost_0_q <= lost_0_q + 1'b1;
         if (!bus.I_1_valid || bus.I_1_ready) lost_1_q <= '0;
         else if (can_issue && lost_1_q != 2'd3) lost_1_q <= lost_1_q + 1'b1;
      end
   end

   a_i0_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
      bus.I_0_valid && !bus.I_0_ready |=> bus.I_0_valid && $stable(bus.I_0_data));
   a_i1_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
      bus.I_1_valid && !bus.I_1_ready |=> bus.I_1_valid && $stable(bus.I_1_data));
   a_du_hold: assert property (@(posedge CLK) disable iff (ASYNCRESET)
      bus.DU_IN_valid && !bus.DU_IN_ready |=> bus.DU_IN_valid);
   a_count:   assert property (@(posedge CLK) disable iff (ASYNCRESET)
      OUTSTANDING <= ($clog2(DEPTH)+1)'(DEPTH));
   a_no_err:  assert property (@(posedge CLK) disable iff (ASYNCRESET) !ERR);
   a_fair_0:  assert property (@(posedge CLK) disable iff (ASYNCRESET) lost_0_q < 2'd2);
   a_fair_1:  assert property (@(posedge CLK) disable iff (ASYNCRESET) lost_1_q < 2'd2);
`endif

endmodule

// File: tb/tb_delay_unit_arbiter.sv
// Self-checking bench for delay_unit_arbiter: directed scenarios plus randomized traffic vs a queue model.
module tb_delay_unit_arbiter;

   localparam int W = 5;
   localparam int D = 4;

   logic         CLK = 1'b0;
   logic         ASYNCRESET;
   logic [2:0]   outstanding;
   logic         err;

   int n_tests = 0;
   int n_fail  = 0;

   delay_unit_arbiter_if #(.WIDTH(W)) bus ();

   delay_unit_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
      .CLK         (CLK),
      .ASYNCRESET  (ASYNCRESET),
      .bus         (bus),
      .OUTSTANDING (outstanding),
      .ERR         (err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: a queue of owner tags ----------------
   bit mq[$];
   bit m_lg  = 1'b1;
   bit m_err = 1'b0;
   bit st_push, st_pop, st_seterr, st_grant;
   bit c_full, c_empty, c_can, c_g, c_head, c_hrdy, c_ov;

   always @(negedge CLK) begin
      st_push   = 1'b0;
      st_pop    = 1'b0;
      st_seterr = 1'b0;
      if (ASYNCRESET) begin
         check("rst_du_in_valid", bus.DU_IN_valid, 0);
         check("rst_i0_ready", bus.I_0_ready, 0);
         check("rst_i1_ready", bus.I_1_ready, 0);
         check("rst_du_out_ready", bus.DU_OUT_ready, 0);
         check("rst_o0_valid", bus.O_0_valid, 0);
         check("rst_o1_valid", bus.O_1_valid, 0);
         check("rst_outstanding", outstanding, 0);
         check("rst_err", err, 0);
      end else begin
         c_full  = (mq.size() == D);
         c_empty = (mq.size() == 0);
         c_can   = bus.DU_IN_ready && !c_full;
         check("m_outstanding", outstanding, mq.size());
         check("m_err", err, m_err);
         if (bus.I_0_valid || bus.I_1_valid) begin
            c_g = (bus.I_0_valid && bus.I_1_valid) ? !m_lg : bus.I_1_valid;
            check("m_du_in_valid", bus.DU_IN_valid, !c_full);
            check("m_du_in_data", bus.DU_IN_data, c_g ? bus.I_1_data : bus.I_0_data);
            check("m_i0_ready", bus.I_0_ready, !c_g && c_can);
            check("m_i1_ready", bus.I_1_ready, c_g && c_can);
            st_push  = c_can;
            st_grant = c_g;
         end else begin
            check("m_du_in_valid_idle", bus.DU_IN_valid, 0);
         end
         c_head = c_empty ? 1'b0 : mq[0];
         c_hrdy = c_head ? bus.O_1_ready : bus.O_0_ready;
         c_ov   = bus.DU_OUT_valid && !c_empty;
         check("m_o0_valid", bus.O_0_valid, c_ov && !c_head);
         check("m_o1_valid", bus.O_1_valid, c_ov && c_head);
         check("m_o0_data", bus.O_0_data, bus.DU_OUT_data);
         check("m_o1_data", bus.O_1_data, bus.DU_OUT_data);
         check("m_du_out_ready", bus.DU_OUT_ready, !c_empty && c_hrdy);
         st_pop    = c_ov && c_hrdy;
         st_seterr = bus.DU_OUT_valid && c_empty;
      end
   end

   always @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         mq.delete();
         m_lg  <= 1'b1;
         m_err <= 1'b0;
      end else begin
         if (st_pop) mq.pop_front();
         if (st_push) begin
            mq.push_back(st_grant);
            m_lg <= st_grant;
         end
         if (st_seterr) m_err <= 1'b1;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic sample();
      @(negedge CLK);
   endtask

   task automatic clear_inputs();
      bus.I_0_valid    = 0; bus.I_0_data = '0;
      bus.I_1_valid    = 0; bus.I_1_data = '0;
      bus.DU_IN_ready  = 0;
      bus.DU_OUT_valid = 0; bus.DU_OUT_data = '0;
      bus.O_0_ready    = 0; bus.O_1_ready = 0;
   endtask

   // Leaves the bench 2 time units after a rising edge, reset released.
   task automatic do_reset();
      @(posedge CLK);
      #2 ASYNCRESET = 1'b1;
      clear_inputs();
      @(posedge CLK);
      #2 ASYNCRESET = 1'b0;
   endtask

   // random-phase bookkeeping
   logic [W-1:0] du_q[$];
   logic [W-1:0] sent0[$];
   logic [W-1:0] sent1[$];
   logic [W-1:0] exp_d;

   initial begin
      bit f0, f1, fin, fout, fo0, fo1;
      logic [W-1:0] d0, d1, din, dout;

      ASYNCRESET = 1'b1;
      clear_inputs();
      bus.I_0_valid = 1; bus.I_1_valid = 1; bus.DU_IN_ready = 1;
      #3;
      check("reset_outstanding", outstanding, 0);
      check("reset_err", err, 0);
      check("reset_du_in_valid", bus.DU_IN_valid, 0);
      check("reset_i0_ready", bus.I_0_ready, 0);
      @(posedge CLK);
      #2 ASYNCRESET = 1'b0;

      // A: alternation from I_0, fill to DEPTH, pop with a blocked push
      bus.I_0_valid = 1; bus.I_0_data = 5'h03;
      bus.I_1_valid = 1; bus.I_1_data = 5'h11;
      bus.DU_IN_ready = 1; bus.O_0_ready = 1; bus.O_1_ready = 1;
      for (int k = 0; k < 4; k++) begin
         sample();
         check("alt_data", bus.DU_IN_data, (k % 2) ? 32'h11 : 32'h03);
         check("alt_count", outstanding, k);
         tick();
      end
      sample();
      check("full_count", outstanding, 4);
      check("full_i0_ready", bus.I_0_ready, 0);
      check("full_i1_ready", bus.I_1_ready, 0);
      tick();
      bus.DU_OUT_valid = 1; bus.DU_OUT_data = 5'h15;
      sample();
      check("full_pop_o0_valid", bus.O_0_valid, 1);
      check("full_pop_du_out_ready", bus.DU_OUT_ready, 1);
      check("full_no_push", bus.DU_IN_valid, 0);
      tick();
      bus.DU_OUT_valid = 0;
      sample();
      check("after_pop_count", outstanding, 3);
      check("after_pop_data", bus.DU_IN_data, 32'h03);
      do_reset();

      // B: I_1 alone streams every cycle; afterwards I_0 wins a tie
      bus.DU_IN_ready = 1; bus.O_0_ready = 1; bus.O_1_ready = 1;
      bus.I_0_valid = 1; bus.I_0_data = 5'h07;
      sample();
      check("b_i0_ready", bus.I_0_ready, 1);
      tick();
      bus.I_0_valid = 0; bus.I_1_valid = 1; bus.I_1_data = 5'h09;
      bus.DU_OUT_valid = 1; bus.DU_OUT_data = 5'h07;
      for (int k = 0; k < 3; k++) begin
         sample();
         check("b_i1_ready", bus.I_1_ready, 1);
         check("b_i1_count", outstanding, (k == 0) ? 1 : k);
         tick();
         bus.DU_OUT_valid = 0;
      end
      bus.I_0_valid = 1;
      sample();
      check("b_tie_i0_ready", bus.I_0_ready, 1);
      check("b_tie_i1_ready", bus.I_1_ready, 0);
      check("b_tie_data", bus.DU_IN_data, 32'h07);
      do_reset();

      // C: issue I_0, I_1, I_1 then steer returns with O_1 back-pressure
      bus.DU_IN_ready = 1;
      bus.I_0_valid = 1; bus.I_0_data = 5'h01;
      sample(); tick();
      bus.I_0_valid = 0; bus.I_1_valid = 1; bus.I_1_data = 5'h02;
      sample(); tick();
      bus.I_1_data = 5'h04;
      sample();
      check("c_count2", outstanding, 2);
      tick();
      bus.I_1_valid = 0;
      tick(); tick();
      bus.DU_OUT_valid = 1; bus.DU_OUT_data = 5'h0A;
      bus.O_0_ready = 1; bus.O_1_ready = 0;
      sample();
      check("c_o0_valid", bus.O_0_valid, 1);
      check("c_o0_data", bus.O_0_data, 32'h0A);
      check("c_o1_valid_idle", bus.O_1_valid, 0);
      check("c_count3", outstanding, 3);
      tick();
      bus.DU_OUT_data = 5'h0B;
      for (int k = 0; k < 2; k++) begin
         sample();
         check("c_o1_held_valid", bus.O_1_valid, 1);
         check("c_o1_held_stall", bus.DU_OUT_ready, 0);
         check("c_o0_quiet", bus.O_0_valid, 0);
         tick();
      end
      bus.O_1_ready = 1;
      sample();
      check("c_o1_b", bus.O_1_data, 32'h0B);
      check("c_o1_b_ready", bus.DU_OUT_ready, 1);
      tick();
      bus.DU_OUT_data = 5'h0C;
      sample();
      check("c_o1_c_valid", bus.O_1_valid, 1);
      check("c_count1", outstanding, 1);
      tick();
      bus.DU_OUT_valid = 0;
      sample();
      check("c_count0", outstanding, 0);
      tick();

      // D: return with an empty FIFO is an error that sticks
      bus.DU_OUT_valid = 1; bus.DU_OUT_data = 5'h1F;
      sample();
      check("d_du_out_ready", bus.DU_OUT_ready, 0);
      check("d_o0_valid", bus.O_0_valid, 0);
      check("d_err_pre", err, 0);
      tick();
      bus.DU_OUT_valid = 0;
      sample();
      check("d_err_set", err, 1);
      tick(); tick();
      sample();
      check("d_err_sticky", err, 1);
      do_reset();
      sample();
      check("d_err_cleared", err, 0);
      tick();

      // E: mid-cycle reset with two beats outstanding after I_1 then I_0
      bus.DU_IN_ready = 1;
      bus.I_1_valid = 1; bus.I_1_data = 5'h12;
      sample(); tick();
      bus.I_1_valid = 0; bus.I_0_valid = 1; bus.I_0_data = 5'h13;
      sample(); tick();
      bus.I_1_valid = 1;
      #1 ASYNCRESET = 1'b1;
      #1;
      check("e_rst_count", outstanding, 0);
      check("e_rst_i0_ready", bus.I_0_ready, 0);
      check("e_rst_du_in_valid", bus.DU_IN_valid, 0);
      #1 ASYNCRESET = 1'b0;
      sample();
      check("e_grant_i0", bus.I_0_ready, 1);
      check("e_grant_i1", bus.I_1_ready, 0);
      check("e_grant_data", bus.DU_IN_data, 32'h13);
      do_reset();

      // Random traffic: the bench acts as requesters, in-order delay unit and sinks
      du_q.delete(); sent0.delete(); sent1.delete();
      for (int c = 0; c < 3000; c++) begin
         sample();
         f0   = bus.I_0_valid && bus.I_0_ready;
         f1   = bus.I_1_valid && bus.I_1_ready;
         fin  = bus.DU_IN_valid && bus.DU_IN_ready;
         fout = bus.DU_OUT_valid && bus.DU_OUT_ready;
         fo0  = bus.O_0_valid && bus.O_0_ready;
         fo1  = bus.O_1_valid && bus.O_1_ready;
         d0 = bus.I_0_data; d1 = bus.I_1_data;
         din = bus.DU_IN_data; dout = bus.DU_OUT_data;
         tick();
         if (f0) sent0.push_back(d0);
         if (f1) sent1.push_back(d1);
         if (fin) du_q.push_back(din);
         if (fout) void'(du_q.pop_front());
         if (fo0) begin
            exp_d = (sent0.size() > 0) ? sent0.pop_front() : ~dout;
            check("e2e_o0", dout, exp_d);
         end
         if (fo1) begin
            exp_d = (sent1.size() > 0) ? sent1.pop_front() : ~dout;
            check("e2e_o1", dout, exp_d);
         end
         if (!bus.I_0_valid || f0) begin
            bus.I_0_valid = ($urandom_range(0, 3) != 0);
            bus.I_0_data  = W'($urandom);
         end
         if (!bus.I_1_valid || f1) begin
            bus.I_1_valid = ($urandom_range(0, 3) != 0);
            bus.I_1_data  = W'($urandom);
         end
         bus.DU_IN_ready = ($urandom_range(0, 3) != 0);
         if (!(bus.DU_OUT_valid && !fout)) begin
            bus.DU_OUT_valid = (du_q.size() > 0) && ($urandom_range(0, 2) != 0);
            bus.DU_OUT_data  = (du_q.size() > 0) ? du_q[0] : W'($urandom);
         end
         bus.O_0_ready = ($urandom_range(0, 3) != 0);
         bus.O_1_ready = ($urandom_range(0, 3) != 0);
      end
      sample();
      check("final_err", err, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
